replica_exchange_sched: RTL

Run-level scheduler for the replica-exchange annealing array. It sequences each iteration: an opt pass on all nodes, a total-distance update, then an even/odd neighbour exchange, with an optional periodic ordering snapshot for host readout. It sits between the bus interface (run command, status) and the node array's phase-control inputs, and replaces ad-hoc free-running sequencing with an explicit handshaked FSM.

---
 rtl/replica_exchange_sched_if.sv | 37 +++
 rtl/replica_exchange_sched.sv | 134 +++++++++++++
 2 files changed

// File: rtl/replica_exchange_sched_if.sv
// Bus-side handshake bundle between the replica-exchange scheduler, the host
// command/status registers and the node array phase controls.
interface replica_exchange_sched_if #(
    parameter int replica_num = 32
);
    logic                   run_write;
    logic [23:0]            run_times;
    logic [15:0]            snap_interval;
    logic                   abort;
    logic                   opt_start;
    logic                   opt_done;
    logic                   dist_start;
    logic                   dist_done;
    logic                   exch_valid;
    logic                   exch_parity;
    logic [replica_num-1:0] exch_pairs;
    logic                   exch_ack;
    logic                   snap_req;
    logic                   snap_ack;
    logic                   running;
    logic [23:0]            iter_count;
    logic                   done;

    modport master (
        output run_write, run_times, snap_interval, abort,
        output opt_done, dist_done, exch_ack, snap_ack,
        input  opt_start, dist_start, exch_valid, exch_parity, exch_pairs,
        input  snap_req, running, iter_count, done
    );

    modport slave (
        input  run_write, run_times, snap_interval, abort,
        input  opt_done, dist_done, exch_ack, snap_ack,
        output opt_start, dist_start, exch_valid, exch_parity, exch_pairs,
        output snap_req, running, iter_count, done
    );
endinterface

// File: rtl/replica_exchange_sched.sv
// Run-level iteration sequencer for the replica-exchange annealing array:
// opt pass, distance update, even/odd exchange, optional periodic snapshot.
//
// state | meaning
// IDLE  | waiting for run_write
// OPT   | opt pass running on all nodes
// DIST  | total-distance update running
// EXCH  | neighbour exchange requested, waiting for exch_ack
// SNAP  | ordering snapshot requested, waiting for snap_ack
module replica_exchange_sched #(
    parameter int replica_num = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    replica_exchange_sched_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, OPT, DIST, EXCH, SNAP} state_t;

    state_t      state;
    logic [23:0] run_times_q;
    logic [15:0] snap_interval_q;
    logic [15:0] snap_cnt;
    logic        abort_pend;
    logic [23:0] iter_next;
    logic        snap_due;

    assign iter_next = bus.iter_count + 24'd1;
    assign snap_due  = (snap_interval_q != 16'd0) && (snap_cnt == 16'd1);

    // Lower member of each active pair; the top replica never leads a pair.
    function automatic logic [replica_num-1:0] pairs_mask(input logic par);
        logic [replica_num-1:0] m;
        m = '0;
        for (int g = 0; g < replica_num - 1; g++) begin
            m[g] = (g[0] == par);
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            run_times_q     <= '0;
            snap_interval_q <= '0;
            snap_cnt        <= '0;
            abort_pend      <= 1'b0;
            bus.opt_start   <= 1'b0;
            bus.dist_start  <= 1'b0;
            bus.exch_valid  <= 1'b0;
            bus.exch_parity <= 1'b0;
            bus.exch_pairs  <= '0;
            bus.snap_req    <= 1'b0;
            bus.running     <= 1'b0;
            bus.iter_count  <= '0;
            bus.done        <= 1'b0;
        end else begin
            bus.opt_start  <= 1'b0;
            bus.dist_start <= 1'b0;
            bus.done       <= 1'b0;
            if (state != IDLE && bus.abort) begin
                abort_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.run_write) begin
                        run_times_q     <= bus.run_times;
                        snap_interval_q <= bus.snap_interval;
                        snap_cnt        <= bus.snap_interval;
                        bus.iter_count  <= '0;
                        abort_pend      <= 1'b0;
                        bus.exch_parity <= 1'b0;
                        if (bus.run_times != 24'd0) begin
                            state         <= OPT;
                            bus.running   <= 1'b1;
                            bus.opt_start <= 1'b1;
                        end else begin
                            bus.done <= 1'b1;
                        end
                    end
                end
                OPT: begin
                    // opt_start doubles as the first-cycle marker, masking opt_done.
                    if (!bus.opt_start && bus.opt_done) begin
                        state          <= DIST;
                        bus.dist_start <= 1'b1;
                    end
                end
                DIST: begin
                    if (!bus.dist_start && bus.dist_done) begin
                        state          <= EXCH;
                        bus.exch_valid <= 1'b1;
                        bus.exch_pairs <= pairs_mask(bus.exch_parity);
                    end
                end
                EXCH: begin
                    if (bus.exch_ack) begin
                        bus.exch_valid  <= 1'b0;
                        bus.exch_pairs  <= '0;
                        bus.iter_count  <= iter_next;
                        bus.exch_parity <= ~bus.exch_parity;
                        if (snap_interval_q != 16'd0) begin
                            snap_cnt <= (snap_cnt == 16'd1) ? snap_interval_q : snap_cnt - 16'd1;
                        end
                        if (snap_due) begin
                            state        <= SNAP;
                            bus.snap_req <= 1'b1;
                        end else if (iter_next == run_times_q || abort_pend) begin
                            state       <= IDLE;
                            bus.running <= 1'b0;
                            bus.done    <= 1'b1;
                        end else begin
                            state         <= OPT;
                            bus.opt_start <= 1'b1;
                        end
                    end
                end
                SNAP: begin
                    if (bus.snap_ack) begin
                        bus.snap_req <= 1'b0;
                        if (bus.iter_count == run_times_q || abort_pend) begin
                            state       <= IDLE;
                            bus.running <= 1'b0;
                            bus.done    <= 1'b1;
                        end else begin
                            state         <= OPT;
                            bus.opt_start <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
